// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
      CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
   } cls_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [1:0] WB_IMM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_MEM = 2'd2;
   localparam logic [1:0] WB_PC4 = 2'd3;

   localparam logic [1:0] TC_NONE    = 2'd0;
   localparam logic [1:0] TC_TIMEOUT = 2'd1;
   localparam logic [1:0] TC_ILLEGAL = 2'd2;

   function automatic cls_e classify(input logic [6:0] opc);
      cls_e c;
      case (opc)
         OPC_OP:     c = CL_OP;
         OPC_OPIMM:  c = CL_OPIMM;
         OPC_LOAD:   c = CL_LOAD;
         OPC_STORE:  c = CL_STORE;
         OPC_BRANCH: c = CL_BRANCH;
         OPC_JAL:    c = CL_JAL;
         OPC_JALR:   c = CL_JALR;
         OPC_LUI:    c = CL_LUI;
         OPC_AUIPC:  c = CL_AUIPC;
         default:    c = CL_ILL;
      endcase
      return c;
   endfunction

   // funct3 010/011 carry no branch encoding; callers trap on them.
   function automatic logic br_legal(input logic [2:0] f3);
      return f3[2:1] != 2'b01;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                     input logic lt, input logic ltu);
      logic t;
      case (f3)
         3'b000:  t = eq;
         3'b001:  t = ~eq;
         3'b100:  t = lt;
         3'b101:  t = ~lt;
         3'b110:  t = ltu;
         3'b111:  t = ~ltu;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Shared memory-latency counter and bus watchdog for the IF/MEM request phases.
module mc_wait_timer #(
   parameter int USE_ACK   = 1,
   parameter int FIXED_LAT = 1,
   parameter int TIMEOUT   = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic req,
   input  logic ack,
   output logic done,
   output logic timeout
);

   localparam int CW = 16;
   localparam logic [CW-1:0] LAT_LAST = CW'(FIXED_LAT - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic          WD_EN    = (USE_ACK != 0) && (TIMEOUT != 0);

   // r_cnt holds the number of request cycles already elapsed in this phase.
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else if (start || !req)
         r_cnt <= '0;
      else if (r_cnt != '1)
         r_cnt <= r_cnt + CW'(1);
   end

   generate
      if (USE_ACK != 0) begin : g_ack
         assign done = req & ack;
      end else begin : g_fixed
         assign done = req & (r_cnt == LAT_LAST);
      end
   endgenerate

   // An ack arriving in the final allowed cycle completes the access instead.
   assign timeout = WD_EN & req & ~ack & (r_cnt == TO_LAST);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I core, with branch
// resolution, bus watchdog and illegal-instruction trap.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int USE_ACK   = 1,
   parameter int FIXED_LAT = 1,
   parameter int TIMEOUT   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       AeqB,
   input  logic       AltB,
   input  logic       AltuB,
   input  logic       im_ack,
   input  logic       dm_ack,
   output logic       im_req,
   output logic       dm_req,
   output logic       dm_write,
   output logic       ir_write,
   output logic       pc_go_next,
   output logic       pc_jump,
   output logic       pc_jump_sel,
   output logic       regs_write,
   output logic [3:0] alu_op,
   output logic       alu_lhs_sel,
   output logic       alu_rhs_sel,
   output logic [1:0] wb_sel,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state
);

   state_e     r_state, w_nxt;
   logic [1:0] r_cause, w_cause_nxt;
   cls_e       w_cls;
   logic       w_taken, w_br_ok;
   logic [3:0] w_alu_op;
   logic       w_lhs, w_rhs;
   logic       w_req, w_ack, w_start, w_done, w_tmo;
   logic       w_unused_f7;

   assign w_cls       = classify(opcode);
   assign w_taken     = br_taken(funct3, AeqB, AltB, AltuB);
   assign w_br_ok     = br_legal(funct3);
   assign w_unused_f7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      w_alu_op = ALU_ADD;
      if (w_cls == CL_OP)
         w_alu_op = {funct7[5], funct3};
      else if (w_cls == CL_OPIMM)
         w_alu_op = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
   end

   assign w_rhs = !(w_cls == CL_OP || w_cls == CL_BRANCH);
   assign w_lhs = (w_cls == CL_AUIPC);

   // Gated by rst so every request drops the instant reset asserts.
   assign w_req   = rst && (r_state == S_IF || r_state == S_MEM);
   assign w_ack   = (r_state == S_IF) ? im_ack : (r_state == S_MEM) ? dm_ack : 1'b0;
   assign w_start = (w_nxt != r_state);

   mc_wait_timer #(
      .USE_ACK  (USE_ACK),
      .FIXED_LAT(FIXED_LAT),
      .TIMEOUT  (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (w_start),
      .req    (w_req),
      .ack    (w_ack),
      .done   (w_done),
      .timeout(w_tmo)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IF;
         r_cause <= TC_NONE;
      end else begin
         r_state <= w_nxt;
         r_cause <= w_cause_nxt;
      end
   end

   always_comb begin
      w_nxt       = r_state;
      w_cause_nxt = r_cause;
      im_req      = 1'b0;
      dm_req      = 1'b0;
      dm_write    = 1'b0;
      ir_write    = 1'b0;
      pc_go_next  = 1'b0;
      pc_jump     = 1'b0;
      pc_jump_sel = 1'b0;
      regs_write  = 1'b0;
      alu_op      = ALU_ADD;
      alu_lhs_sel = 1'b0;
      alu_rhs_sel = 1'b0;
      wb_sel      = WB_IMM;
      if (rst) begin
         case (r_state)
            S_IF: begin
               im_req = 1'b1;
               if (w_done) begin
                  ir_write = 1'b1;
                  w_nxt    = S_ID;
               end else if (w_tmo) begin
                  w_nxt       = S_TRAP;
                  w_cause_nxt = TC_TIMEOUT;
               end
            end
            S_ID: begin
               if (w_cls == CL_ILL) begin
                  w_nxt       = S_TRAP;
                  w_cause_nxt = TC_ILLEGAL;
               end else begin
                  w_nxt = S_EX;
               end
            end
            S_EX: begin
               alu_op      = w_alu_op;
               alu_lhs_sel = w_lhs;
               alu_rhs_sel = w_rhs;
               if (w_cls == CL_BRANCH) begin
                  if (!w_br_ok) begin
                     w_nxt       = S_TRAP;
                     w_cause_nxt = TC_ILLEGAL;
                  end else begin
                     pc_jump    = w_taken;
                     pc_go_next = ~w_taken;
                     w_nxt      = S_IF;
                  end
               end else if (w_cls == CL_LOAD || w_cls == CL_STORE) begin
                  w_nxt = S_MEM;
               end else begin
                  w_nxt = S_WB;
               end
            end
            S_MEM: begin
               alu_op      = w_alu_op;
               alu_lhs_sel = w_lhs;
               alu_rhs_sel = w_rhs;
               dm_req      = 1'b1;
               dm_write    = (w_cls == CL_STORE);
               if (w_done) begin
                  if (w_cls == CL_STORE) begin
                     pc_go_next = 1'b1;
                     w_nxt      = S_IF;
                  end else begin
                     w_nxt = S_WB;
                  end
               end else if (w_tmo) begin
                  w_nxt       = S_TRAP;
                  w_cause_nxt = TC_TIMEOUT;
               end
            end
            S_WB: begin
               // ALU stays driven so alu_f (and the JALR target) is valid here.
               alu_op      = w_alu_op;
               alu_lhs_sel = w_lhs;
               alu_rhs_sel = w_rhs;
               regs_write  = 1'b1;
               w_nxt       = S_IF;
               case (w_cls)
                  CL_LUI:  wb_sel = WB_IMM;
                  CL_LOAD: wb_sel = WB_MEM;
                  CL_JAL, CL_JALR: wb_sel = WB_PC4;
                  default: wb_sel = WB_ALU;
               endcase
               if (w_cls == CL_JAL) begin
                  pc_jump = 1'b1;
               end else if (w_cls == CL_JALR) begin
                  pc_jump     = 1'b1;
                  pc_jump_sel = 1'b1;
               end else begin
                  pc_go_next = 1'b1;
               end
            end
            S_TRAP: w_nxt = S_TRAP;
            default: w_nxt = S_IF;
         endcase
      end
   end

   assign trap       = (r_state == S_TRAP);
   assign trap_cause = r_cause;
   assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction cycle/pulse accounting against
// hand-computed expectations, plus trap, watchdog and fixed-latency cases.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic [6:0] funct7 = 7'd0;
   logic       AeqB = 1'b0, AltB = 1'b0, AltuB = 1'b0;
   logic       im_ack = 1'b0, dm_ack = 1'b0;

   logic       im_req, dm_req, dm_write, ir_write, pc_go_next, pc_jump, pc_jump_sel;
   logic       regs_write, alu_lhs_sel, alu_rhs_sel, trap;
   logic [3:0] alu_op;
   logic [1:0] wb_sel, trap_cause;
   logic [2:0] state;

   logic       f_im_req, f_dm_req, f_dm_write, f_ir_write, f_pcn, f_pcj, f_pcjs;
   logic       f_rw, f_lhs, f_rhs, f_trap;
   logic [3:0] f_alu_op;
   logic [1:0] f_wb_sel, f_cause;
   logic [2:0] f_state;

   mc_ctrl #(.USE_ACK(1), .FIXED_LAT(1), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .AeqB(AeqB), .AltB(AltB), .AltuB(AltuB), .im_ack(im_ack), .dm_ack(dm_ack),
      .im_req(im_req), .dm_req(dm_req), .dm_write(dm_write), .ir_write(ir_write),
      .pc_go_next(pc_go_next), .pc_jump(pc_jump), .pc_jump_sel(pc_jump_sel),
      .regs_write(regs_write), .alu_op(alu_op), .alu_lhs_sel(alu_lhs_sel),
      .alu_rhs_sel(alu_rhs_sel), .wb_sel(wb_sel), .trap(trap),
      .trap_cause(trap_cause), .state(state)
   );

   mc_ctrl #(.USE_ACK(0), .FIXED_LAT(3), .TIMEOUT(0)) u_fix (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .AeqB(AeqB), .AltB(AltB), .AltuB(AltuB), .im_ack(im_ack), .dm_ack(dm_ack),
      .im_req(f_im_req), .dm_req(f_dm_req), .dm_write(f_dm_write), .ir_write(f_ir_write),
      .pc_go_next(f_pcn), .pc_jump(f_pcj), .pc_jump_sel(f_pcjs),
      .regs_write(f_rw), .alu_op(f_alu_op), .alu_lhs_sel(f_lhs),
      .alu_rhs_sel(f_rhs), .wb_sel(f_wb_sel), .trap(f_trap),
      .trap_cause(f_cause), .state(f_state)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   int     cyc, n_pcn, n_pcj, n_rw, n_imreq, n_dmreq, n_dmw, rw_cyc, j_cyc, j_sel;
   int     w_wbsel, x_alu, x_lhs, x_rhs;
   longint seq;

   task automatic set_insn(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
      opcode = opc;
      funct3 = f3;
      funct7 = f7;
   endtask

   // Runs one instruction until it returns to IF or traps; iw/dw are wait cycles before ack.
   task automatic run_insn(input int iw, input int dw);
      int ic, dc, prev;
      bit fin;
      ic = 0; dc = 0; fin = 0;
      cyc = 0; n_pcn = 0; n_pcj = 0; n_rw = 0; n_imreq = 0; n_dmreq = 0; n_dmw = 0;
      rw_cyc = -1; j_cyc = -1; j_sel = -1; w_wbsel = -1; x_alu = -1; x_lhs = -1; x_rhs = -1;
      seq = 0;
      for (int k = 0; k < 60 && !fin; k++) begin
         im_ack = (state == 3'd0) && (ic >= iw);
         dm_ack = (state == 3'd3) && (dc >= dw);
         #1;
         cyc++;
         seq  = seq * 8 + longint'(state);
         prev = int'(state);
         if (state == 3'd0) ic++;
         if (state == 3'd3) dc++;
         if (im_req)   n_imreq++;
         if (dm_req)   n_dmreq++;
         if (dm_write) n_dmw++;
         if (pc_go_next) n_pcn++;
         if (pc_jump) begin n_pcj++; j_cyc = cyc; j_sel = int'(pc_jump_sel); end
         if (regs_write) begin n_rw++; rw_cyc = cyc; w_wbsel = int'(wb_sel); end
         if (state == 3'd2) begin
            x_alu = int'(alu_op); x_lhs = int'(alu_lhs_sel); x_rhs = int'(alu_rhs_sel);
         end
         @(posedge clk); #1;
         if ((state == 3'd0 && prev != 0) || state == 3'd5) fin = 1;
      end
      im_ack = 1'b0;
      dm_ack = 1'b0;
      if (!fin) chk("insn_bound", 0, 1);
   endtask

   task automatic rst_pulse();
      rst = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_im_req", int'(im_req), 0);
      chk("rst_dm_req", int'(dm_req), 0);
      chk("rst_trap", int'(trap), 0);
      chk("rst_cause", int'(trap_cause), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rel_im_req", int'(im_req), 1);
   endtask

   int hold_bad, f_ir_cyc, f_ir_n, f_wb_cyc;

   initial begin
      rst_pulse();

      // ADDI x1,x0,5
      set_insn(7'b0010011, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("addi_cyc", cyc, 4);
      chk("addi_seq", int'(seq), 84);
      chk("addi_rw_n", n_rw, 1);
      chk("addi_rw_cyc", rw_cyc, 4);
      chk("addi_wbsel", w_wbsel, 1);
      chk("addi_alu", x_alu, 0);
      chk("addi_rhs", x_rhs, 1);
      chk("addi_pcn", n_pcn, 1);
      chk("addi_pcj", n_pcj, 0);
      chk("addi_imreq", n_imreq, 1);

      run_insn(2, 0);
      chk("addi_w2_cyc", cyc, 6);

      // LW, dm_ack after 3 wait cycles
      set_insn(7'b0000011, 3'b010, 7'd0);
      run_insn(0, 3);
      chk("lw_cyc", cyc, 8);
      chk("lw_dmreq", n_dmreq, 4);
      chk("lw_dmw", n_dmw, 0);
      chk("lw_wbsel", w_wbsel, 2);
      chk("lw_pcn", n_pcn, 1);

      // SW
      set_insn(7'b0100011, 3'b010, 7'd0);
      run_insn(0, 0);
      chk("sw_cyc", cyc, 4);
      chk("sw_dmw", n_dmw, 1);
      chk("sw_rw", n_rw, 0);
      chk("sw_pcn", n_pcn, 1);

      // BLT taken / not taken
      set_insn(7'b1100011, 3'b100, 7'd0);
      AltB = 1'b1;
      run_insn(0, 0);
      chk("blt_t_cyc", cyc, 3);
      chk("blt_t_pcj", n_pcj, 1);
      chk("blt_t_jcyc", j_cyc, 3);
      chk("blt_t_sel", j_sel, 0);
      chk("blt_t_pcn", n_pcn, 0);
      chk("blt_t_rw", n_rw, 0);
      chk("blt_rhs", x_rhs, 0);
      AltB = 1'b0;
      run_insn(0, 0);
      chk("blt_n_pcn", n_pcn, 1);
      chk("blt_n_pcj", n_pcj, 0);
      chk("blt_n_rw", n_rw, 0);

      // BGEU with AltuB=0 is taken; BNE with AeqB=1 is not; BEQ with AeqB=1 is
      set_insn(7'b1100011, 3'b111, 7'd0);
      AltuB = 1'b0;
      run_insn(0, 0);
      chk("bgeu_pcj", n_pcj, 1);
      set_insn(7'b1100011, 3'b001, 7'd0);
      AeqB = 1'b1;
      run_insn(0, 0);
      chk("bne_pcn", n_pcn, 1);
      set_insn(7'b1100011, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("beq_pcj", n_pcj, 1);
      AeqB = 1'b0;

      // JALR / JAL
      set_insn(7'b1100111, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("jalr_cyc", cyc, 4);
      chk("jalr_wbsel", w_wbsel, 3);
      chk("jalr_jcyc", j_cyc, 4);
      chk("jalr_sel", j_sel, 1);
      chk("jalr_pcn", n_pcn, 0);
      set_insn(7'b1101111, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("jal_wbsel", w_wbsel, 3);
      chk("jal_sel", j_sel, 0);

      // LUI / AUIPC
      set_insn(7'b0110111, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("lui_wbsel", w_wbsel, 0);
      chk("lui_pcn", n_pcn, 1);
      set_insn(7'b0010111, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("auipc_wbsel", w_wbsel, 1);
      chk("auipc_lhs", x_lhs, 1);

      // ALU op derivation
      set_insn(7'b0110011, 3'b000, 7'b0100000);
      run_insn(0, 0);
      chk("sub_alu", x_alu, 8);
      chk("sub_rhs", x_rhs, 0);
      set_insn(7'b0110011, 3'b011, 7'd0);
      run_insn(0, 0);
      chk("sltu_alu", x_alu, 3);
      set_insn(7'b0010011, 3'b101, 7'b0100000);
      run_insn(0, 0);
      chk("srai_alu", x_alu, 13);
      set_insn(7'b0010011, 3'b000, 7'b0100000);
      run_insn(0, 0);
      chk("addi_f7_alu", x_alu, 0);

      // Ack in the 8th request cycle beats the watchdog
      run_insn(7, 0);
      chk("ack8_cyc", cyc, 11);
      chk("ack8_trap", int'(trap), 0);
      chk("ack8_pcn", n_pcn, 1);

      // Illegal branch funct3
      set_insn(7'b1100011, 3'b010, 7'd0);
      run_insn(0, 0);
      chk("brill_cyc", cyc, 3);
      chk("brill_cause", int'(trap_cause), 2);
      chk("brill_pc", n_pcn + n_pcj, 0);
      rst_pulse();

      // Illegal opcode 0x7F, held 20 cycles
      set_insn(7'h7F, 3'b000, 7'd0);
      run_insn(0, 0);
      chk("ill_cyc", cyc, 2);
      chk("ill_trap", int'(trap), 1);
      chk("ill_cause", int'(trap_cause), 2);
      chk("ill_pcn", n_pcn, 0);
      hold_bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (!trap || trap_cause != 2'd2 || im_req || dm_req || pc_go_next || pc_jump || regs_write || ir_write)
            hold_bad++;
      end
      chk("ill_hold", hold_bad, 0);
      rst_pulse();
      chk("ill_restart_state", int'(state), 0);

      // Watchdog: no im_ack ever
      set_insn(7'b0010011, 3'b000, 7'd0);
      run_insn(1000, 0);
      chk("wd_imreq", n_imreq, 8);
      chk("wd_trap", int'(trap), 1);
      chk("wd_cause", int'(trap_cause), 1);

      // Reset mid-store aborts the memory access immediately
      rst_pulse();
      set_insn(7'b0100011, 3'b010, 7'd0);
      for (int k = 0; k < 10 && state != 3'd3; k++) begin
         im_ack = 1'b1;
         @(posedge clk); #1;
      end
      im_ack = 1'b0;
      #1;
      chk("mid_dmreq", int'(dm_req), 1);
      chk("mid_dmw", int'(dm_write), 1);
      rst_pulse();
      chk("mid_dmw_after", int'(dm_write), 0);

      // Fixed-latency instance: ir_write on the 3rd im_req cycle
      set_insn(7'b0010011, 3'b000, 7'd0);
      f_ir_cyc = -1; f_ir_n = 0; f_wb_cyc = -1;
      for (int k = 1; k <= 8; k++) begin
         #1;
         if (f_im_req && f_ir_cyc < 0) f_ir_n++;
         if (f_ir_write && f_ir_cyc < 0) f_ir_cyc = k;
         if (f_rw && f_wb_cyc < 0) f_wb_cyc = k;
         @(posedge clk); #1;
      end
      chk("fix_ir_cyc", f_ir_cyc, 3);
      chk("fix_imreq", f_ir_n, 3);
      chk("fix_wb_cyc", f_wb_cyc, 6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
